// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register-bank arbiter.
package reg_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TMR_W  = 8;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Access latched from the granted requester and presented to the register bank.
    typedef struct packed {
        logic              wr_rd_s;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } acc_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/reg_arb.sv
// Arbitrates two requesters onto a single register-bank port with ack timeout.
module reg_arb
    import reg_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr_rd_s0,
    input  logic              wr_rd_s1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              sel_en,
    output logic              wr_rd_s,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ack
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              last_q, last_d;
    acc_t              acc_q, acc_d;
    logic              sel_en_d, done0_d, done1_d, err_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              grant;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign wr_rd_s = acc_q.wr_rd_s;
    assign addr    = acc_q.addr;
    assign wr_data = acc_q.wr_data;

    // last_q doubles as the in-flight owner once a grant is taken.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        last_d    = last_q;
        acc_d     = acc_q;
        sel_en_d  = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_o;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    last_d        = grant;
                    acc_d.wr_rd_s = grant ? wr_rd_s1 : wr_rd_s0;
                    acc_d.addr    = grant ? addr1    : addr0;
                    acc_d.wr_data = grant ? wr_data1 : wr_data0;
                    timer_d       = '0;
                    sel_en_d      = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                timer_d  = timer_q + TMR_W'(1);
                sel_en_d = 1'b1;
                // ack wins over a coincident timeout
                if (ack || (timer_q == TMR_LAST)) begin
                    done0_d   = ~last_q;
                    done1_d   = last_q;
                    err_d     = ~ack;
                    rd_data_d = (ack && (acc_q.wr_rd_s == OP_RD)) ? rd_data : '0;
                    sel_en_d  = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            last_q    <= 1'b1;
            acc_q     <= '0;
            sel_en    <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            rd_data_o <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
            sel_en    <= sel_en_d;
            done0     <= done0_d;
            done1     <= done1_d;
            err       <= err_d;
            rd_data_o <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_reg_arb.sv
// Bench for reg_arb: transaction-level model, bank responder, directed and random traffic.
module tb_reg_arb;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, wr_rd_s0 = 1'b0, wr_rd_s1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wr_data0 = 8'h00, wr_data1 = 8'h00;
    logic [7:0] rd_data = 8'h00;
    logic       ack = 1'b0;
    logic       done0, done1, err, sel_en, wr_rd_s;
    logic [7:0] rd_data_o, addr, wr_data;

    reg_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr_rd_s0(wr_rd_s0), .wr_rd_s1(wr_rd_s1),
        .addr0(addr0), .addr1(addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .done0(done0), .done1(done1), .err(err), .rd_data_o(rd_data_o),
        .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .ack(ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an access is busy for some cycles, then one cool-down cycle.
    bit         m_active = 1'b0, m_cool = 1'b0, m_last = 1'b1, m_who = 1'b0, m_op = 1'b0;
    int         m_age = 0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00;
    logic       e_done0 = 1'b0, e_done1 = 1'b0, e_err = 1'b0, e_sel = 1'b0;
    logic [7:0] e_rd = 8'h00;

    task automatic model_reset();
        m_active = 1'b0; m_cool = 1'b0; m_last = 1'b1; m_who = 1'b0; m_op = 1'b0;
        m_age = 0; m_addr = 8'h00; m_wdata = 8'h00;
        e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0; e_sel = 1'b0; e_rd = 8'h00;
    endtask

    task automatic model_finish(input bit timed_out, input logic [7:0] rd);
        if (m_who) e_done1 = 1'b1; else e_done0 = 1'b1;
        e_err = timed_out;
        e_rd = rd;
        m_active = 1'b0;
        m_cool = 1'b1;
    endtask

    task automatic model_step();
        e_done0 = 1'b0; e_done1 = 1'b0; e_err = 1'b0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (ack) model_finish(1'b0, m_op ? 8'h00 : rd_data);
            else if (m_age == int'(TIMEOUT)) model_finish(1'b1, 8'h00);
        end else if (req0 || req1) begin
            if (req0 && req1) m_who = ~m_last;
            else m_who = req1;
            m_last = m_who;
            m_op = m_who ? wr_rd_s1 : wr_rd_s0;
            m_addr = m_who ? addr1 : addr0;
            m_wdata = m_who ? wr_data1 : wr_data0;
            m_active = 1'b1;
            m_age = 0;
        end
        e_sel = m_active;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("sel_en", sel_en, e_sel);
                check("wr_rd_s", wr_rd_s, m_op);
                check("addr", addr, m_addr);
                check("wr_data", wr_data, m_wdata);
                check("done0", done0, e_done0);
                check("done1", done1, e_done1);
                check("err", err, e_err);
                check("rd_data_o", rd_data_o, e_rd);
                check("done_excl", done0 & done1, 1'b0);
            end
        end
    end

    // Register-bank responder: ack after a chosen number of ACCESS cycles, optional spurious acks.
    int         bank_delay = 2;
    int         cur_delay = 2;
    int         acc_n = 0;
    bit         bank_rand = 1'b0;
    bit         spur = 1'b0;
    logic [7:0] mem [256];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7);
        mem[2] = 8'h3C;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            rd_data = 8'($urandom);
            if (sel_en) begin
                if (acc_n == 0)
                    cur_delay = bank_rand ? (($urandom % 5 == 0) ? 1000 : int'($urandom_range(0, 17)))
                                          : bank_delay;
                if (acc_n == cur_delay) begin
                    ack = 1'b1;
                    if (wr_rd_s) mem[addr] = wr_data;
                    else rd_data = mem[addr];
                end
                acc_n++;
            end else begin
                acc_n = 0;
                if (spur || (bank_rand && ($urandom % 4 == 0))) ack = 1'b1;
            end
        end
    end

    task automatic set_req(input bit who, input bit v, input bit op, input logic [7:0] a, input logic [7:0] d);
        if (who) begin req1 = v; wr_rd_s1 = op; addr1 = a; wr_data1 = d; end
        else begin req0 = v; wr_rd_s0 = op; addr0 = a; wr_data0 = d; end
    endtask

    task automatic access(input bit who, input bit op, input logic [7:0] a, input logic [7:0] d,
                          output logic e, output logic [7:0] rd, output int n_sel);
        bit got = 1'b0;
        n_sel = 0;
        e = 1'bx;
        rd = 8'hxx;
        set_req(who, 1'b1, op, a, d);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (sel_en) n_sel++;
            if (who ? done1 : done0) begin
                got = 1'b1;
                e = err;
                rd = rd_data_o;
            end
        end
        set_req(who, 1'b0, op, a, d);
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL access_wait: got no done expected done%0d at %0t", who, $time);
        end
    endtask

    logic       t_err;
    logic [7:0] t_rd;
    int         t_sel;
    bit         order [$];
    bit         exp_ord [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sel_en", sel_en, 1'b0);
        check("rst_rd_data_o", rd_data_o, 8'h00);
        check("rst_addr", addr, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, read, read-back
        bank_delay = 2;
        access(1'b0, 1'b1, 8'h01, 8'hA5, t_err, t_rd, t_sel);
        check("wr_err", t_err, 1'b0);
        check("wr_sel_cycles", 8'(t_sel), 8'd3);
        access(1'b1, 1'b0, 8'h02, 8'h00, t_err, t_rd, t_sel);
        check("rd_err", t_err, 1'b0);
        check("rd_data", t_rd, 8'h3C);
        access(1'b1, 1'b0, 8'h01, 8'h00, t_err, t_rd, t_sel);
        check("readback", t_rd, 8'hA5);

        // Both held: alternate 0,1,0,1
        bank_delay = 1;
        begin
            bit drop0 = 1'b0, drop1 = 1'b0;
            set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
            set_req(1'b1, 1'b1, 1'b0, 8'h11, 8'h00);
            for (int i = 0; i < 200 && order.size() < 4; i++) begin
                @(negedge clk);
                if (drop0) begin req0 = 1'b1; drop0 = 1'b0; end
                if (drop1) begin req1 = 1'b1; drop1 = 1'b0; end
                if (done0) begin order.push_back(1'b0); req0 = 1'b0; drop0 = 1'b1; end
                if (done1) begin order.push_back(1'b1); req1 = 1'b0; drop1 = 1'b1; end
            end
            req0 = 1'b0;
            req1 = 1'b0;
        end
        check("rr_count", 8'(order.size()), 8'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("rr_order", order[i], exp_ord[i]);
        repeat (3) @(negedge clk);

        // Timeout
        bank_delay = 1000;
        access(1'b0, 1'b0, 8'h05, 8'h00, t_err, t_rd, t_sel);
        check("to_err", t_err, 1'b1);
        check("to_rd", t_rd, 8'h00);
        check("to_sel_cycles", 8'(t_sel), 8'd16);
        repeat (2) @(negedge clk);

        // Spurious acks in IDLE and RELEASE
        spur = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("spur_idle_done", done0 | done1, 1'b0);
            check("spur_idle_sel", sel_en, 1'b0);
        end
        bank_delay = 0;
        access(1'b0, 1'b0, 8'h03, 8'h00, t_err, t_rd, t_sel);
        check("spur_rd", t_rd, 8'h15);
        repeat (3) begin
            @(negedge clk);
            check("spur_rel_done", done0 | done1, 1'b0);
        end
        spur = 1'b0;

        // Reset in the middle of an access
        bank_delay = 1000;
        begin
            int cnt = 0;
            set_req(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
            for (int i = 0; i < 50 && cnt < 3; i++) begin
                @(negedge clk);
                if (sel_en) cnt++;
            end
            check("pre_rst_sel", sel_en, 1'b1);
            rst_n = 1'b0;
            #1;
            check("mid_rst_sel", sel_en, 1'b0);
            check("mid_rst_done", done0 | done1, 1'b0);
            req0 = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check("rst_hold_done", done0 | done1, 1'b0);
            end
            rst_n = 1'b1;
        end
        bank_delay = 1;
        begin
            bit got0 = 1'b0, got1 = 1'b0, first_set = 1'b0, first = 1'b1;
            set_req(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
            set_req(1'b1, 1'b1, 1'b0, 8'h04, 8'h00);
            for (int i = 0; i < 100 && !(got0 && got1); i++) begin
                @(negedge clk);
                if (done0) begin got0 = 1'b1; req0 = 1'b0; if (!first_set) begin first = 1'b0; first_set = 1'b1; end end
                if (done1) begin got1 = 1'b1; req1 = 1'b0; if (!first_set) begin first = 1'b1; first_set = 1'b1; end end
            end
            req0 = 1'b0;
            req1 = 1'b0;
            check("post_rst_first", first, 1'b0);
            check("post_rst_both", got0 & got1, 1'b1);
        end
        repeat (3) @(negedge clk);

        // Random traffic
        bank_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req0 && done0) req0 = 1'b0;
            else if (!req0 && ($urandom % 3 == 0))
                set_req(1'b0, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            if (req1 && done1) req1 = 1'b0;
            else if (!req1 && ($urandom % 3 == 0))
                set_req(1'b1, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        bank_rand = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
